// File: rtl/ds_dac_mc_if.sv
// Sample port of the multi-channel delta-sigma DAC.
// The producer side drives the master modport and the DAC takes the slave side.
interface ds_dac_mc_if #(
    parameter int WIDTH = 8,
    parameter int CW    = 1
);
    logic             s_valid;
    logic             s_ready;
    logic [CW-1:0]    s_chan;
    logic [WIDTH-1:0] s_data;

    modport master (
        output s_valid, s_chan, s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid, s_chan, s_data,
        output s_ready
    );
endinterface

// File: rtl/ds_dac_mc.sv
// N-channel delta-sigma DAC with first/second order shaping.
// Samples are held one deep per channel and committed together on frame boundaries.
module ds_dac_mc #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2,
    parameter int OSR_LOG2 = 6,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    ds_dac_mc_if.slave          s,
    input  logic                order2,
    output logic                frame_tick,
    output logic [CHANNELS-1:0] bit_out
);
    localparam int IW = WIDTH + 4;
    localparam int SW = WIDTH + 6;
    localparam logic signed [SW-1:0] SMAX = SW'(2**(IW-1) - 1);
    localparam logic signed [SW-1:0] SMIN = SW'(-(2**(IW-1)));
    localparam logic signed [SW-1:0] XLO  = SW'(2**(WIDTH-4));
    localparam logic signed [SW-1:0] XHI  = SW'(2**WIDTH - 2**(WIDTH-4));
    localparam logic signed [SW-1:0] FULL = SW'(2**WIDTH);

    logic [OSR_LOG2-1:0] cnt;
    logic [OSR_LOG2-1:0] cnt_inc;
    logic                mode;
    logic                clr;
    logic                rdy;
    logic [CHANNELS-1:0] wr;
    logic [CHANNELS-1:0] pend_valid;
    logic [WIDTH-1:0]    pend   [CHANNELS];
    logic [WIDTH-1:0]    active [CHANNELS];
    logic [WIDTH-1:0]    acc    [CHANNELS];
    logic [WIDTH:0]      sum1   [CHANNELS];
    logic signed [IW-1:0] i1    [CHANNELS];
    logic signed [IW-1:0] i2    [CHANNELS];
    logic signed [IW-1:0] i1n   [CHANNELS];
    logic signed [IW-1:0] i2n   [CHANNELS];

    function automatic logic signed [SW-1:0] ext(input logic signed [IW-1:0] v);
        return {{(SW-IW){v[IW-1]}}, v};
    endfunction

    function automatic logic signed [IW-1:0] sat(input logic signed [SW-1:0] v);
        if (v > SMAX) return SMAX[IW-1:0];
        else if (v < SMIN) return SMIN[IW-1:0];
        else return v[IW-1:0];
    endfunction

    // Keep the second-order loop away from full scale where it goes unstable.
    function automatic logic signed [SW-1:0] clampx(input logic [WIDTH-1:0] a);
        logic signed [SW-1:0] v;
        v = {{(SW-WIDTH){1'b0}}, a};
        if (v < XLO) return XLO;
        else if (v > XHI) return XHI;
        else return v;
    endfunction

    function automatic logic signed [SW-1:0] fbk(input logic b);
        return b ? FULL : '0;
    endfunction

    assign cnt_inc   = cnt + 1'b1;
    assign clr       = frame_tick & (order2 != mode);
    assign s.s_ready = rdy;

    always_comb begin
        rdy = 1'b1;
        for (int c = 0; c < CHANNELS; c++) begin
            if (s.s_chan == CW'(c)) rdy = ~pend_valid[c];
        end
        for (int c = 0; c < CHANNELS; c++) begin
            wr[c] = s.s_valid & rdy & (s.s_chan == CW'(c));
        end
    end

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            sum1[c] = {1'b0, acc[c]} + {1'b0, active[c]};
            i1n[c]  = sat(ext(i1[c]) + clampx(active[c]) - fbk(bit_out[c]));
            i2n[c]  = sat(ext(i2[c]) + ext(i1n[c]) - fbk(bit_out[c]));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            frame_tick <= 1'b0;
            mode       <= 1'b0;
            pend_valid <= '0;
            bit_out    <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                pend[c]   <= '0;
                active[c] <= '0;
                acc[c]    <= '0;
                i1[c]     <= '0;
                i2[c]     <= '0;
            end
        end else begin
            cnt        <= cnt_inc;
            frame_tick <= &cnt_inc;
            if (frame_tick) mode <= order2;
            for (int c = 0; c < CHANNELS; c++) begin
                if (wr[c]) begin
                    pend[c]       <= s.s_data;
                    pend_valid[c] <= 1'b1;
                end else if (frame_tick && pend_valid[c]) begin
                    active[c]     <= pend[c];
                    pend_valid[c] <= 1'b0;
                end
                if (clr) begin
                    acc[c]     <= '0;
                    i1[c]      <= '0;
                    i2[c]      <= '0;
                    bit_out[c] <= 1'b0;
                end else if (mode) begin
                    i1[c]      <= i1n[c];
                    i2[c]      <= i2n[c];
                    bit_out[c] <= ~i2n[c][IW-1];
                end else begin
                    acc[c]     <= sum1[c][WIDTH-1:0];
                    bit_out[c] <= sum1[c][WIDTH];
                end
            end
        end
    end
endmodule

// File: tb/tb_ds_dac_mc.sv
// Directed bench for ds_dac_mc: handshake, frame commit, ones density, mode switch, reset.
// Three channels so that s_chan = 3 is a reachable out-of-range index.
module tb_ds_dac_mc;
    localparam int W   = 8;
    localparam int CH  = 3;
    localparam int OSR = 6;
    localparam int CW  = 2;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic          order2  = 1'b0;
    logic          frame_tick;
    logic [CH-1:0] bit_out;

    ds_dac_mc_if #(.WIDTH(W), .CW(CW)) s_if ();

    ds_dac_mc #(
        .WIDTH(W), .CHANNELS(CH), .OSR_LOG2(OSR)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s         (s_if.slave),
        .order2    (order2),
        .frame_tick(frame_tick),
        .bit_out   (bit_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int k0, k1, k2, n;

    task automatic chk(string tag, int got, int exp, int tol = 0);
        checks++;
        if (got < exp - tol || got > exp + tol) begin
            errors++;
            $display("FAIL %s got %0d exp %0d tol %0d", tag, got, exp, tol);
        end
    endtask

    // All tasks start and end at a falling edge.
    task automatic tick_wait();
        int m = 0;
        do begin
            @(negedge clk);
            m++;
        end while (!frame_tick && m < 200);
        if (!frame_tick) chk("tick_timeout", 0, 1);
    endtask

    task automatic send(input int ch, input int d);
        int m = 0;
        s_if.s_valid = 1'b1;
        s_if.s_chan  = CW'(ch);
        s_if.s_data  = W'(d);
        while (!s_if.s_ready && m < 300) begin
            @(negedge clk);
            m++;
        end
        if (!s_if.s_ready) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1 s_if.s_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic count(input int len, output int c0, output int c1, output int c2);
        c0 = 0; c1 = 0; c2 = 0;
        repeat (len) begin
            @(negedge clk);
            c0 += int'(bit_out[0]);
            c1 += int'(bit_out[1]);
            c2 += int'(bit_out[2]);
        end
    endtask

    initial begin
        s_if.s_valid = 1'b0;
        s_if.s_chan  = '0;
        s_if.s_data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_bits", int'(bit_out), 0);
        chk("rst_tick", int'(frame_tick), 0);
        chk("rst_ready", int'(s_if.s_ready), 1);
        reset_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 200);
        chk("first_tick", n, 63);
        @(negedge clk);

        // first order, 64 and 192
        send(0, 64);
        send(1, 192);
        tick_wait();
        @(negedge clk);
        count(256, k0, k1, k2);
        chk("fo64_a", k0, 64);
        chk("fo192_a", k1, 192);
        count(256, k0, k1, k2);
        chk("fo64_b", k0, 64);
        chk("fo192_b", k1, 192);

        // extremes
        send(0, 0);
        send(1, 255);
        tick_wait();
        @(negedge clk);
        count(256, k0, k1, k2);
        chk("fo0", k0, 0);
        chk("fo255", k1, 255);

        // second write to a full channel stalls until after the boundary
        send(0, 100);
        s_if.s_valid = 1'b1;
        s_if.s_chan  = 2'd0;
        s_if.s_data  = 8'd200;
        chk("hs_stall", int'(s_if.s_ready), 0);
        tick_wait();
        chk("hs_stall_tick", int'(s_if.s_ready), 0);
        @(negedge clk);
        chk("hs_ready", int'(s_if.s_ready), 1);
        @(posedge clk);
        #1 s_if.s_valid = 1'b0;
        count(64, k0, k1, k2);
        chk("hs_val100", k0, 25);
        count(64, k0, k1, k2);
        chk("hs_val200", k0, 50);

        // out-of-range channel, then a write in the tick cycle
        s_if.s_chan = 2'd3;
        #1 chk("oob_ready", int'(s_if.s_ready), 1);
        send(3, 77);
        tick_wait();
        send(1, 128);
        count(64, k0, k1, k2);
        chk("tw_old255", k1, 64, 1);
        n = k0;
        count(64, k0, k1, k2);
        chk("tw_new128", k1, 32);
        chk("oob_ch0", n + k0, 100);
        chk("oob_ch2", k2, 0);

        // switch to second order mid-frame
        send(0, 128);
        send(1, 255);
        order2 = 1'b1;
        k2 = 0;
        n  = 0;
        do begin
            @(negedge clk);
            k2 += int'(bit_out[2]);
            n++;
        end while (!frame_tick && n < 200);
        chk("mode_hold", k2, 0);
        @(negedge clk);
        chk("mode_clear", int'(bit_out), 0);
        @(negedge clk);
        chk("so_first", int'(bit_out), 7);
        count(1024, k0, k1, k2);
        chk("so128", k0, 512, 2);
        chk("so255", k1, 960, 2);
        chk("so0", k2, 64, 2);

        // back to first order
        order2 = 1'b0;
        tick_wait();
        @(negedge clk);
        chk("fo_clear", int'(bit_out), 0);
        count(256, k0, k1, k2);
        chk("back128", k0, 128);
        chk("back255", k1, 255);
        chk("back0", k2, 0);

        // reset mid-frame with a pending sample
        send(1, 50);
        repeat (10) @(negedge clk);
        #2 reset_n = 1'b0;
        s_if.s_chan = 2'd1;
        #1;
        chk("mrst_bits", int'(bit_out), 0);
        chk("mrst_tick", int'(frame_tick), 0);
        chk("mrst_ready", int'(s_if.s_ready), 1);
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 200);
        chk("mrst_tick_pos", n, 63);
        count(128, k0, k1, k2);
        chk("mrst_ch0", k0, 0);
        chk("mrst_lost", k1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
